lane_scroll_controller: RTL and testbench
=========================================

LANE_SCROLL_CONTROLLER -- requirements
Module: lane_scroll_controller

Interface
REQ-001 The block SHALL have parameter X_FRAME, default 640, meaning visible pixels per line and the offset modulus.
REQ-002 The block SHALL have parameter BANK_WIDTH, default 80, meaning bank height in lines at the top and bottom of the screen.
REQ-003 The block SHALL have parameter LANE_H, default 40, meaning river lane height in lines.
REQ-004 The block SHALL have parameter NUM_LANES, default 8, meaning river lane count (river spans y 80..399).
REQ-005 The block SHALL have port CLK  in  1  system clock, all flops rising-edge.
REQ-006 The block SHALL have port RESETn  in  1  reset, asynchronous, active-high (1 = in reset).
REQ-007 The block SHALL have port startOfFrame  in  1  one-cycle pulse at vertical blanking.
REQ-008 The block SHALL have port oCoord_X  in  11  current pixel X from the VGA controller.
REQ-009 The block SHALL have port oCoord_Y  in  11  current pixel Y from the VGA controller.
REQ-010 The block SHALL have port cfg_we  in  1  lane config write strobe.
REQ-011 The block SHALL have port cfg_lane  in  3  lane index for the write.
REQ-012 The block SHALL have port cfg_speed  in  4  pixels per frame, 0..15.
REQ-013 The block SHALL have port cfg_dir  in  1  0 = offset increments (scroll left), 1 = offset decrements.
REQ-014 The block SHALL have port pause  in  1  1 = skip offset updates.
REQ-015 The block SHALL have port lane_valid  out  1  pixel lies in a river lane.
REQ-016 The block SHALL have port lane_idx  out  3  lane of the current pixel.
REQ-017 The block SHALL have port scroll_X  out  10  lane-scrolled X coordinate.
REQ-018 The block SHALL have port update_busy  out  1  the FSM is in UPDATE.
REQ-019 The block SHALL have port frame_cnt  out  8  frames updated, wraps 255->0.
REQ-020 The block SHALL have port overrun  out  1  sticky: startOfFrame arrived while busy.

Function
REQ-021 The block SHALL hold per lane: offset (10 bit, 0..639), speed (4 bit) and dir (1 bit).
REQ-022 The FSM SHALL have states IDLE and UPDATE.
REQ-023 In IDLE, startOfFrame=1 with pause=0 SHALL enter UPDATE with lane counter 0 and assert update_busy on the next cycle.
REQ-024 In IDLE, startOfFrame=1 with pause=1 SHALL leave the state, offsets and frame_cnt unchanged.
REQ-025 In UPDATE, each cycle SHALL update lane k = counter: dir=0 -> offset=(offset+speed) mod 640; dir=1 -> offset=(offset-speed) mod 640, wrapping below 0 to 640-n.
REQ-026 After lane NUM_LANES-1 is updated, the FSM SHALL return to IDLE and frame_cnt SHALL increment; UPDATE lasts exactly NUM_LANES cycles.
REQ-027 startOfFrame during UPDATE SHALL be ignored and SHALL set overrun to 1; overrun is cleared only by reset.
REQ-028 pause asserted mid-UPDATE SHALL NOT abort the sweep.
REQ-029 cfg_we=1 SHALL write speed/dir of cfg_lane at the clock edge, in any state.
REQ-030 If cfg_we targets the lane being updated in the same cycle, that update SHALL use the old speed/dir.
REQ-031 The pixel path SHALL be registered with 1-cycle latency from oCoord_X/Y.
REQ-032 The pixel path SHALL decode lane = (Y-80)/40 for 80<=Y<=399 and X<640, giving lane_valid=1 and scroll_X=(X+offset[lane]) mod 640.
REQ-033 Otherwise (bank lines, Y>399, X>=640) the pixel path SHALL drive lane_valid=0, lane_idx=0, scroll_X=0.
REQ-034 The pixel path SHALL use offset values as registered before the current clock edge.

Reset
REQ-035 While RESETn=1, all offsets, speeds, dirs, frame_cnt, overrun, lane_valid, lane_idx, scroll_X and update_busy SHALL be 0 and the FSM SHALL be in IDLE, independent of CLK.
REQ-036 Reset asserted mid-UPDATE SHALL abandon the sweep; after release the FSM SHALL wait in IDLE for the next startOfFrame.

Verification
REQ-037 Reset sequence: after release, X=100,Y=85 -> next cycle lane_valid=1, lane_idx=0, scroll_X=100.
REQ-038 Lane 3 configured speed=5, dir=0; 130 frames -> offset[3]=650 mod 640=10; X=635,Y=200 -> scroll_X=5.
REQ-039 Lane 0 configured speed=3, dir=1; 1 frame -> offset 637; X=2,Y=80 -> scroll_X=639.
REQ-040 Second startOfFrame 4 cycles after the first -> overrun=1, frame_cnt +1 only, update_busy high for exactly 8 cycles.
REQ-041 pause=1 with startOfFrame -> offsets and frame_cnt unchanged; Y=79 or Y=400 -> lane_valid=0, scroll_X=0.
REQ-042 cfg_we to lane 2 on the cycle lane 2 updates (old speed 1, new speed 7) -> offset +1 this frame, +7 the next.

Source files
------------

// File: rtl/lane_scroll_controller.sv
// Per-lane horizontal scroll offsets for a river-crossing playfield: a frame-rate
// sweep FSM advances each lane's offset, and a registered pixel path remaps X per lane.
module lane_scroll_controller #(
    parameter int X_FRAME    = 640,
    parameter int BANK_WIDTH = 80,
    parameter int LANE_H     = 40,
    parameter int NUM_LANES  = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic [10:0] oCoord_X,
    input  logic [10:0] oCoord_Y,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_lane,
    input  logic [3:0]  cfg_speed,
    input  logic        cfg_dir,
    input  logic        pause,
    output logic        lane_valid,
    output logic [2:0]  lane_idx,
    output logic [9:0]  scroll_X,
    output logic        update_busy,
    output logic [7:0]  frame_cnt,
    output logic        overrun
);

    localparam logic [10:0] X_FRAME_W  = 11'(X_FRAME);
    localparam logic [10:0] RIVER_TOP  = 11'(BANK_WIDTH);
    localparam logic [10:0] RIVER_END  = 11'(BANK_WIDTH + NUM_LANES * LANE_H);
    localparam logic [2:0]  LAST_LANE  = 3'(NUM_LANES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    state_t      state_r;
    logic [2:0]  lane_cnt_r;
    logic [9:0]  offset_r [NUM_LANES];
    logic [3:0]  speed_r  [NUM_LANES];
    logic        dir_r    [NUM_LANES];
    logic        update_busy_r;
    logic [7:0]  frame_cnt_r;
    logic        overrun_r;

    logic [9:0]  cur_off_s;
    logic [3:0]  cur_spd_s;
    logic        cur_dir_s;
    logic [10:0] sum_up_s;
    logic [9:0]  next_off_s;

    logic        pix_valid_s;
    logic [2:0]  pix_idx_s;
    logic [10:0] pix_sum_s;
    logic [9:0]  pix_scroll_s;
    logic        lane_valid_r;
    logic [2:0]  lane_idx_r;
    logic [9:0]  scroll_x_r;

    // Next offset of the lane under sweep; reads speed/dir before any same-cycle config write.
    always_comb begin
        cur_off_s  = offset_r[lane_cnt_r];
        cur_spd_s  = speed_r[lane_cnt_r];
        cur_dir_s  = dir_r[lane_cnt_r];
        sum_up_s   = {1'b0, cur_off_s} + {7'd0, cur_spd_s};
        next_off_s = cur_off_s;
        if (cur_dir_s == 1'b0) begin
            if (sum_up_s >= X_FRAME_W) begin
                next_off_s = 10'(sum_up_s - X_FRAME_W);
            end else begin
                next_off_s = sum_up_s[9:0];
            end
        end else begin
            if (cur_off_s >= {6'd0, cur_spd_s}) begin
                next_off_s = cur_off_s - {6'd0, cur_spd_s};
            end else begin
                next_off_s = 10'(X_FRAME_W + {1'b0, cur_off_s} - {7'd0, cur_spd_s});
            end
        end
    end

    // Frame sweep FSM: one lane per cycle, frame counter and sticky overrun flag.
    always_ff @(posedge CLK or posedge RESETn) begin
        if (RESETn) begin
            state_r       <= IDLE;
            lane_cnt_r    <= 3'd0;
            update_busy_r <= 1'b0;
            frame_cnt_r   <= 8'd0;
            overrun_r     <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                offset_r[i] <= 10'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (startOfFrame && !pause) begin
                        state_r       <= UPDATE;
                        lane_cnt_r    <= 3'd0;
                        update_busy_r <= 1'b1;
                    end
                end
                UPDATE: begin
                    offset_r[lane_cnt_r] <= next_off_s;
                    if (startOfFrame) begin
                        overrun_r <= 1'b1;
                    end
                    if (lane_cnt_r == LAST_LANE) begin
                        state_r       <= IDLE;
                        lane_cnt_r    <= 3'd0;
                        update_busy_r <= 1'b0;
                        frame_cnt_r   <= frame_cnt_r + 8'd1;
                    end else begin
                        lane_cnt_r <= lane_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    lane_cnt_r    <= 3'd0;
                    update_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Lane configuration writes, accepted in any FSM state.
    always_ff @(posedge CLK or posedge RESETn) begin
        if (RESETn) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                speed_r[i] <= 4'd0;
                dir_r[i]   <= 1'b0;
            end
        end else if (cfg_we) begin
            speed_r[cfg_lane] <= cfg_speed;
            dir_r[cfg_lane]   <= cfg_dir;
        end
    end

    // Pixel decode: lane from Y by threshold compare, X shifted by that lane's offset.
    always_comb begin
        pix_valid_s  = 1'b0;
        pix_idx_s    = 3'd0;
        pix_sum_s    = 11'd0;
        pix_scroll_s = 10'd0;
        if (oCoord_Y >= RIVER_TOP && oCoord_Y < RIVER_END && oCoord_X < X_FRAME_W) begin
            pix_valid_s = 1'b1;
            for (int k = 1; k < NUM_LANES; k++) begin
                pix_idx_s = (oCoord_Y >= 11'(BANK_WIDTH + k * LANE_H)) ? 3'(k) : pix_idx_s;
            end
            pix_sum_s = oCoord_X + {1'b0, offset_r[pix_idx_s]};
            if (pix_sum_s >= X_FRAME_W) begin
                pix_scroll_s = 10'(pix_sum_s - X_FRAME_W);
            end else begin
                pix_scroll_s = pix_sum_s[9:0];
            end
        end else begin
            pix_valid_s  = 1'b0;
            pix_idx_s    = 3'd0;
            pix_scroll_s = 10'd0;
        end
    end

    // Pixel path output registers.
    always_ff @(posedge CLK or posedge RESETn) begin
        if (RESETn) begin
            lane_valid_r <= 1'b0;
            lane_idx_r   <= 3'd0;
            scroll_x_r   <= 10'd0;
        end else begin
            lane_valid_r <= pix_valid_s;
            lane_idx_r   <= pix_idx_s;
            scroll_x_r   <= pix_scroll_s;
        end
    end

    assign lane_valid  = lane_valid_r;
    assign lane_idx    = lane_idx_r;
    assign scroll_X    = scroll_x_r;
    assign update_busy = update_busy_r;
    assign frame_cnt   = frame_cnt_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_lane_scroll_controller.sv
// Directed self-checking bench for lane_scroll_controller with hand-computed expectations.
module tb_lane_scroll_controller;

    logic        CLK;
    logic        RESETn;
    logic        startOfFrame;
    logic [10:0] oCoord_X;
    logic [10:0] oCoord_Y;
    logic        cfg_we;
    logic [2:0]  cfg_lane;
    logic [3:0]  cfg_speed;
    logic        cfg_dir;
    logic        pause;
    logic        lane_valid;
    logic [2:0]  lane_idx;
    logic [9:0]  scroll_X;
    logic        update_busy;
    logic [7:0]  frame_cnt;
    logic        overrun;

    int tests_run;
    int tests_failed;
    int busy_cycles;

    lane_scroll_controller dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .startOfFrame (startOfFrame),
        .oCoord_X     (oCoord_X),
        .oCoord_Y     (oCoord_Y),
        .cfg_we       (cfg_we),
        .cfg_lane     (cfg_lane),
        .cfg_speed    (cfg_speed),
        .cfg_dir      (cfg_dir),
        .pause        (pause),
        .lane_valid   (lane_valid),
        .lane_idx     (lane_idx),
        .scroll_X     (scroll_X),
        .update_busy  (update_busy),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pix(input int x, input int y, input int exp_valid, input int exp_idx,
                       input int exp_scroll, input string tag);
        oCoord_X = 11'(x);
        oCoord_Y = 11'(y);
        tick();
        check_val({tag, "_valid"},  int'(lane_valid), exp_valid);
        check_val({tag, "_idx"},    int'(lane_idx),   exp_idx);
        check_val({tag, "_scroll"}, int'(scroll_X),   exp_scroll);
    endtask

    task automatic cfg(input int lane, input int spd, input int dir);
        cfg_we    = 1'b1;
        cfg_lane  = 3'(lane);
        cfg_speed = 4'(spd);
        cfg_dir   = 1'(dir);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check_val("busy_start", int'(update_busy), 1);
        repeat (8) tick();
        check_val("busy_end", int'(update_busy), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RESETn       = 1'b1;
        startOfFrame = 1'b0;
        oCoord_X     = 11'd100;
        oCoord_Y     = 11'd85;
        cfg_we       = 1'b0;
        cfg_lane     = 3'd0;
        cfg_speed    = 4'd0;
        cfg_dir      = 1'b0;
        pause        = 1'b0;

        // Reset state
        repeat (3) tick();
        check_val("rst_valid",   int'(lane_valid),  0);
        check_val("rst_scroll",  int'(scroll_X),    0);
        check_val("rst_busy",    int'(update_busy), 0);
        check_val("rst_fcnt",    int'(frame_cnt),   0);
        check_val("rst_overrun", int'(overrun),     0);
        RESETn = 1'b0;

        pix(100, 85, 1, 0, 100, "post_rst");

        // Lane 0 scrolls right by 3 per frame: wraps 0 -> 637
        cfg(0, 3, 1);
        do_frame();
        check_val("fcnt_1", int'(frame_cnt), 1);
        pix(2, 80, 1, 0, 639, "lane0_wrap");

        // Lane 3 at 5 px/frame for 130 frames: 650 mod 640 = 10; lane 0 at 637-390 = 247
        cfg(3, 5, 0);
        repeat (130) do_frame();
        check_val("fcnt_131", int'(frame_cnt), 131);
        pix(635, 200, 1, 3, 5,   "lane3_wrap");
        pix(0,   119, 1, 0, 247, "lane0_bottom");
        pix(639, 120, 1, 1, 639, "lane1_top");
        pix(10,  399, 1, 7, 10,  "lane7_last");
        pix(10,  400, 0, 0, 0,   "bank_400");
        pix(10,  79,  0, 0, 0,   "bank_79");
        pix(640, 200, 0, 0, 0,   "x_640");

        // Paused frame start is dropped entirely
        pause        = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check_val("pause_busy", int'(update_busy), 0);
        repeat (9) tick();
        pause = 1'b0;
        check_val("pause_fcnt", int'(frame_cnt), 131);
        pix(0, 200, 1, 3, 10, "pause_off3");

        // Overrun: second start 4 cycles into the sweep
        busy_cycles  = 0;
        startOfFrame = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            startOfFrame = (i == 3) ? 1'b1 : 1'b0;
            if (update_busy) busy_cycles++;
        end
        check_val("ovr_busy_cycles", busy_cycles, 8);
        check_val("ovr_flag", int'(overrun), 1);
        check_val("ovr_fcnt", int'(frame_cnt), 132);
        pix(0, 200, 1, 3, 15,  "ovr_off3");
        pix(0, 80,  1, 0, 244, "ovr_off0");

        // Config collision on lane 2 plus pause mid-sweep
        cfg(2, 1, 0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        pause = 1'b1;
        tick();
        cfg_we    = 1'b1;
        cfg_lane  = 3'd2;
        cfg_speed = 4'd7;
        cfg_dir   = 1'b0;
        tick();
        cfg_we = 1'b0;
        check_val("midpause_busy", int'(update_busy), 1);
        repeat (5) tick();
        pause = 1'b0;
        check_val("coll_busy_end", int'(update_busy), 0);
        check_val("coll_fcnt", int'(frame_cnt), 133);
        pix(0, 160, 1, 2, 1,  "coll_old_speed");
        pix(0, 200, 1, 3, 20, "coll_off3");
        do_frame();
        check_val("next_fcnt", int'(frame_cnt), 134);
        pix(5, 160, 1, 2, 13, "coll_new_speed");
        check_val("ovr_sticky", int'(overrun), 1);

        // Reset in the middle of a sweep
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
        RESETn = 1'b1;
        #1;
        check_val("midrst_busy",    int'(update_busy), 0);
        check_val("midrst_fcnt",    int'(frame_cnt),   0);
        check_val("midrst_overrun", int'(overrun),     0);
        check_val("midrst_scroll",  int'(scroll_X),    0);
        tick();
        RESETn = 1'b0;
        repeat (10) tick();
        check_val("postrst_idle", int'(update_busy), 0);
        check_val("postrst_fcnt", int'(frame_cnt),   0);
        pix(635, 200, 1, 3, 635, "postrst_off3");
        do_frame();
        check_val("postrst_frame", int'(frame_cnt), 1);
        pix(635, 200, 1, 3, 635, "postrst_speed0");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
